// File: rtl/config_usb_cdc_pkg.sv
// config_usb_cdc_pkg: sync bytes, command codes and TX FSM states shared by the CDC config link.
// CSUM state only exists when CONFIG_USB_CDC_TX_CHECKSUM_EN is defined.
package config_usb_cdc_pkg;
    localparam logic [7:0] SYNC0         = 8'h00;
    localparam logic [7:0] SYNC1         = 8'hAA;
    localparam logic [7:0] SYNC2         = 8'hFF;
    localparam logic [7:0] CMD_WRITE     = 8'h01;
    localparam logic [7:0] CMD_WRITE_ALT = 8'h02;
    localparam logic [7:0] CMD_READBACK  = 8'h03;
`ifdef CONFIG_USB_CDC_TX_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HEADER, DATA, CSUM} tx_state_t;
`else
    typedef enum logic [1:0] {IDLE, HEADER, DATA} tx_state_t;
`endif
endpackage

// File: rtl/config_tx_word_fifo.sv
// config_tx_word_fifo: synchronous FIFO; push at full and pop at empty are ignored.
module config_tx_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/config_usb_cdc_tx.sv
// config_usb_cdc_tx: frames buffered 32-bit words as 00 AA FF <cmd> + MSB-first payload on the CDC IN stream.
// Define CONFIG_USB_CDC_TX_CHECKSUM_EN to append an XOR checksum byte over the payload.
module config_usb_cdc_tx
    import config_usb_cdc_pkg::*;
#(
    parameter int         WORDS_PER_FRAME = 4,
    parameter int         FIFO_DEPTH      = 4,
    parameter logic [7:0] RESPONSE_CMD    = CMD_READBACK
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] word_data_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    output logic [7:0]  in_data_o,
    output logic        in_valid_o,
    input  logic        in_ready_i,
    output logic        busy_o,
    output logic        frame_done_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    tx_state_t state;
    logic [1:0] idx;
    logic [23:0] sh;
    logic [7:0] wcnt, hdr_next;
    logic [31:0] fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic fifo_full, fifo_empty, fifo_pop, rdy_q, hs, last_byte, more;
`ifdef CONFIG_USB_CDC_TX_CHECKSUM_EN
    logic [7:0] csum;
`endif
    config_tx_word_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (word_valid_i && word_ready_o),
        .wdata   (word_data_i),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );
    assign word_ready_o = rdy_q && !fifo_full;
    assign busy_o       = state != IDLE;
    assign hs           = in_valid_o && in_ready_i;
    assign last_byte    = hs && idx == 2'd3;
    assign more         = wcnt != 8'(WORDS_PER_FRAME);
    assign hdr_next     = (idx == 2'd0) ? SYNC1 : (idx == 2'd1) ? SYNC2 : RESPONSE_CMD;
    // Fetch a word when starved in DATA or right at the boundary byte so bytes stay back-to-back
    assign fifo_pop = !fifo_empty && ((state == DATA && !in_valid_o) ||
                      (last_byte && (state == HEADER || (state == DATA && more))));
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdy_q        <= 1'b0;
            state        <= IDLE;
            idx          <= '0;
            sh           <= '0;
            wcnt         <= '0;
            in_valid_o   <= 1'b0;
            in_data_o    <= 8'h00;
            frame_done_o <= 1'b0;
`ifdef CONFIG_USB_CDC_TX_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            rdy_q        <= 1'b1;
            frame_done_o <= 1'b0;
            case (state)
                IDLE: if (fifo_count != '0) begin
                    state      <= HEADER;
                    in_data_o  <= SYNC0;
                    in_valid_o <= 1'b1;
                    idx        <= '0;
                    wcnt       <= '0;
                end
                HEADER: if (hs) begin
                    idx       <= idx + 2'd1;
                    in_data_o <= hdr_next;
                    if (idx == 2'd3) begin
                        state      <= DATA;
                        in_valid_o <= 1'b0;
                    end
                end
                DATA: if (hs && idx != 2'd3) begin
                    in_data_o <= sh[23:16];
                    sh        <= {sh[15:0], 8'h00};
                    idx       <= idx + 2'd1;
                end else if (hs && !more) begin
`ifdef CONFIG_USB_CDC_TX_CHECKSUM_EN
                    state     <= CSUM;
                    in_data_o <= csum ^ in_data_o;
`else
                    state        <= IDLE;
                    in_valid_o   <= 1'b0;
                    frame_done_o <= 1'b1;
`endif
                end else if (hs) begin
                    in_valid_o <= 1'b0;
                end
`ifdef CONFIG_USB_CDC_TX_CHECKSUM_EN
                CSUM: if (hs) begin
                    state        <= IDLE;
                    in_valid_o   <= 1'b0;
                    frame_done_o <= 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
            if (fifo_pop) begin
                state      <= DATA;
                sh         <= fifo_rdata[23:0];
                in_data_o  <= fifo_rdata[31:24];
                in_valid_o <= 1'b1;
                idx        <= '0;
                wcnt       <= wcnt + 8'd1;
            end
`ifdef CONFIG_USB_CDC_TX_CHECKSUM_EN
            if (state == IDLE) csum <= '0;
            else if (state == DATA && hs) csum <= csum ^ in_data_o;
`endif
        end
    end
endmodule

// File: tb/tb_config_usb_cdc_tx.sv
// tb_config_usb_cdc_tx: scoreboard bench; u1 runs 1-word frames, u2 runs 2-word frames for the starvation case.
module tb_config_usb_cdc_tx;
`ifdef CONFIG_USB_CDC_TX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    logic clk = 1'b0;
    logic reset_i;
    logic [31:0] wd1, wd2;
    logic wv1, wv2, wr1, wr2, iv1, iv2, ir1, ir2, b1, b2, fd1, fd2;
    logic [7:0] id1, id2;
    logic [7:0] exp1[$], exp2[$];
    logic [7:0] cs_m;
    int checks = 0, failures = 0;
    int n;

    always #5 clk = ~clk;

    config_usb_cdc_tx #(.WORDS_PER_FRAME(1), .FIFO_DEPTH(4), .RESPONSE_CMD(8'h03)) u1 (
        .clk_i(clk), .reset_i(reset_i), .word_data_i(wd1), .word_valid_i(wv1), .word_ready_o(wr1),
        .in_data_o(id1), .in_valid_o(iv1), .in_ready_i(ir1), .busy_o(b1), .frame_done_o(fd1));
    config_usb_cdc_tx #(.WORDS_PER_FRAME(2), .FIFO_DEPTH(4), .RESPONSE_CMD(8'h03)) u2 (
        .clk_i(clk), .reset_i(reset_i), .word_data_i(wd2), .word_valid_i(wv2), .word_ready_o(wr2),
        .in_data_o(id2), .in_valid_o(iv2), .in_ready_i(ir2), .busy_o(b2), .frame_done_o(fd2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic exp_byte(input int d, input logic [7:0] b);
        if (d == 1) exp1.push_back(b);
        else exp2.push_back(b);
        cs_m = cs_m ^ b;
    endtask

    task automatic exp_hdr(input int d);
        exp_byte(d, 8'h00);
        exp_byte(d, 8'hAA);
        exp_byte(d, 8'hFF);
        exp_byte(d, 8'h03);
        cs_m = 8'h00;
    endtask

    task automatic exp_word(input int d, input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_byte(d, w[i*8 +: 8]);
    endtask

    task automatic exp_end(input int d);
        if (CS == 1) exp_byte(d, cs_m);
    endtask

    task automatic push(input int d, input logic [31:0] w);
        if (d == 1) begin
            wd1 = w; wv1 = 1'b1;
            chk("push_ready_u1", wr1, 1);
            @(posedge clk); #1 wv1 = 1'b0;
        end else begin
            wd2 = w; wv2 = 1'b1;
            chk("push_ready_u2", wr2, 1);
            @(posedge clk); #1 wv2 = 1'b0;
        end
    endtask

    task automatic wait_done(input int d, input int lim, output int cyc);
        cyc = -1;
        for (int i = 1; i <= lim; i++) begin
            @(posedge clk); #1;
            if ((d == 1) ? fd1 : fd2) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic mon_byte(input int d, input logic [7:0] b);
        logic [7:0] e;
        if ((d == 1 ? exp1.size() : exp2.size()) == 0) begin
            checks++;
            failures++;
            $display("FAIL u%0d_unexpected_byte actual=%h required=none", d, b);
        end else begin
            e = (d == 1) ? exp1.pop_front() : exp2.pop_front();
            chk(d == 1 ? "u1_byte" : "u2_byte", b, e);
        end
    endtask

    always @(negedge clk) begin
        if (iv1 && ir1) mon_byte(1, id1);
        if (iv2 && ir2) mon_byte(2, id2);
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fw [5];
        int acc;
        fw[0] = 32'h11111111; fw[1] = 32'h22222222; fw[2] = 32'h33333333;
        fw[3] = 32'h44444444; fw[4] = 32'h55555555;
        cs_m = 8'h00;
        reset_i = 1'b1;
        wd1 = '0; wd2 = '0; wv1 = 1'b0; wv2 = 1'b0; ir1 = 1'b1; ir2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", iv1, 0);
        chk("rst_data", id1, 8'h00);
        chk("rst_busy", b1, 0);
        chk("rst_done", fd1, 0);
        chk("rst_word_ready", wr1, 0);
        reset_i = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", wr1, 1);

        // basic single-word frame, back-to-back
        exp_hdr(1); exp_word(1, 32'hDEADBEEF); exp_end(1);
        push(1, 32'hDEADBEEF);
        wait_done(1, 30, n);
        chk("basic_frame_cycles", n, 9 + CS);
        chk("busy_low_at_done", b1, 0);
        @(posedge clk); #1;
        chk("done_one_cycle", fd1, 0);

        // backpressure on AA
        ir1 = 1'b0;
        exp_hdr(1); exp_word(1, 32'h12345678); exp_end(1);
        push(1, 32'h12345678);
        @(posedge clk); #1;
        chk("bp_first_byte", {iv1, id1}, {1'b1, 8'h00});
        ir1 = 1'b1;
        @(posedge clk); #1;
        ir1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_aa", {iv1, id1}, {1'b1, 8'hAA});
        end
        ir1 = 1'b1;
        wait_done(1, 30, n);
        chk("bp_frame_done", n > 0, 1);

        // FIFO full with the endpoint stalled
        ir1 = 1'b0;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            exp_hdr(1); exp_word(1, fw[k]); exp_end(1);
        end
        for (int k = 0; k < 5; k++) begin
            wd1 = fw[k]; wv1 = 1'b1;
            if (wr1) acc++;
            @(posedge clk); #1;
        end
        chk("full_accepted", acc, 4);
        chk("full_word_ready", wr1, 0);
        ir1 = 1'b1;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (wr1) begin
                n = i;
                break;
            end
        end
        chk("full_ready_after_pop", n, 4);
        @(posedge clk); #1 wv1 = 1'b0;
        for (int i = 0; i < 300 && (exp1.size() != 0 || b1); i++) begin
            @(posedge clk); #1;
        end
        chk("full_drained", exp1.size(), 0);

        // starvation mid-frame on the 2-word instance
        exp_hdr(2); exp_word(2, 32'h0A0B0C0D);
        push(2, 32'h0A0B0C0D);
        repeat (12) @(posedge clk);
        #1;
        chk("starve_valid", iv2, 0);
        chk("starve_busy", b2, 1);
        exp_word(2, 32'h01020304); exp_end(2);
        push(2, 32'h01020304);
        wait_done(2, 30, n);
        chk("starve_resume_cycles", n, 5 + CS);

        // reset in the middle of the payload
        exp_hdr(1);
        exp1.push_back(8'hA1);
        exp1.push_back(8'hB2);
        push(1, 32'hA1B2C3D4);
        repeat (7) @(posedge clk);
        #1;
        chk("mid_byte2", {iv1, id1}, {1'b1, 8'hC3});
        reset_i = 1'b1;
        #1;
        chk("mid_rst_valid", iv1, 0);
        chk("mid_rst_data", id1, 8'h00);
        chk("mid_rst_busy", b1, 0);
        chk("mid_rst_word_ready", wr1, 0);
        chk("mid_rst_consumed", exp1.size(), 0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(posedge clk); #1;
        exp_hdr(1); exp_word(1, 32'h55667788); exp_end(1);
        push(1, 32'h55667788);
        wait_done(1, 30, n);
        chk("post_rst_frame_cycles", n, 9 + CS);

        chk("u1_queue_empty", exp1.size(), 0);
        chk("u2_queue_empty", exp2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
